// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge-to-memory bridge.
package cart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold
  } cart_state_e;

  // Value the bus floats to when nothing has been read.
  localparam logic [7:0] IdleData = 8'hFF;

  localparam int unsigned DefaultAddrW = 23;

endpackage

// File: rtl/cart_mem_bridge_if.sv
// External memory request port: level request, one-cycle acknowledge pulse.
interface cart_mem_bridge_if #(
  parameter int unsigned ADDR_W = cart_pkg::DefaultAddrW
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_a,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_a,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/cart_sync.sv
// N-stage synchroniser for one active-high level, with rising-edge detect on the synced output.
module cart_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              prev_q;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[Stages-1];
    end
  end

  assign q_o    = sync_q[Stages-1];
  assign rise_o = sync_q[Stages-1] & ~prev_q;

endmodule

// File: rtl/cart_mem_bridge.sv
// Turns each mapped MSX cartridge cycle into one external memory request, stalling the Z80 via
// wait_n. Define CART_READ_CACHE_EN to add a single-entry read cache.
module cart_mem_bridge
  import cart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned ADDR_W         = DefaultAddrW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cart_ena,
  input  logic              ram_ena,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [7:0]        cdin,
  output logic [7:0]        cdout,
  output logic              cdout_oe,
  output logic              wait_n,
  output logic              timeout_flag,
  cart_mem_bridge_if.master mem
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic rd_s, wr_s, ce_s, rd_rise, wr_rise, unused_ce_rise;
  logic start, strobe, hit;

  cart_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d, wait_q, wait_d;
  logic              oe_q, oe_d, tflag_q, tflag_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [7:0]        wdata_q, wdata_d, cdout_q, cdout_d;

  cart_sync #(.Stages(SYNC_STAGES)) u_sync_rd (
    .clk_i (clk),
    .rst_ni(reset_n),
    .d_i   (~rd_n),
    .q_o   (rd_s),
    .rise_o(rd_rise)
  );

  cart_sync #(.Stages(SYNC_STAGES)) u_sync_wr (
    .clk_i (clk),
    .rst_ni(reset_n),
    .d_i   (~wr_n),
    .q_o   (wr_s),
    .rise_o(wr_rise)
  );

  cart_sync #(.Stages(SYNC_STAGES)) u_sync_ce (
    .clk_i (clk),
    .rst_ni(reset_n),
    .d_i   (cart_ena),
    .q_o   (ce_s),
    .rise_o(unused_ce_rise)
  );

  assign strobe = rd_s | wr_s;
  // Exactly one strobe newly active; both together never starts a cycle.
  assign start  = ce_s & ((rd_rise & ~wr_s) | (wr_rise & ~rd_s));

`ifdef CART_READ_CACHE_EN
  logic              cvld_q, cvld_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;
  logic [7:0]        cdata_q, cdata_d;

  assign hit = cvld_q && (caddr_q == mem_addr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cvld_q  <= 1'b0;
      caddr_q <= '0;
      cdata_q <= 8'h00;
    end else begin
      cvld_q  <= cvld_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    a_d     = a_q;
    wdata_d = wdata_q;
    wait_d  = wait_q;
    cdout_d = cdout_q;
    oe_d    = oe_q;
    tflag_d = tflag_q;
`ifdef CART_READ_CACHE_EN
    cvld_d  = cvld_q;
    caddr_d = caddr_q;
    cdata_d = cdata_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (rd_s && hit) begin
`ifdef CART_READ_CACHE_EN
            cdout_d = cdata_q;
`endif
            oe_d    = 1'b1;
            state_d = StHold;
          end else if (rd_s || ram_ena) begin
            state_d = StReq;
            req_d   = 1'b1;
            wait_d  = 1'b0;
            we_d    = wr_s;
            a_d     = mem_addr;
            wdata_d = cdin;
            cnt_d   = '0;
`ifdef CART_READ_CACHE_EN
            if (wr_s) cvld_d = 1'b0;
`endif
          end else begin
            // ROM-mode write is a bank-register access handled by the mapper.
            state_d = StHold;
          end
        end
      end
      StReq: begin
        if (mem.mem_ack || (cnt_q == CntLast)) begin
          req_d   = 1'b0;
          wait_d  = 1'b1;
          state_d = strobe ? StHold : StIdle;
          if (mem.mem_ack) begin
            if (!we_q && strobe) begin
              cdout_d = mem.mem_rdata;
              oe_d    = 1'b1;
`ifdef CART_READ_CACHE_EN
              cvld_d  = 1'b1;
              caddr_d = a_q;
              cdata_d = mem.mem_rdata;
`endif
            end
          end else begin
            tflag_d = 1'b1;
`ifdef CART_READ_CACHE_EN
            cvld_d  = 1'b0;
`endif
            if (!we_q && strobe) begin
              cdout_d = IdleData;
              oe_d    = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (!strobe) begin
          oe_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      a_q     <= '0;
      wdata_q <= 8'h00;
      wait_q  <= 1'b1;
      cdout_q <= IdleData;
      oe_q    <= 1'b0;
      tflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      a_q     <= a_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      cdout_q <= cdout_d;
      oe_q    <= oe_d;
      tflag_q <= tflag_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_a     = a_q;
  assign mem.mem_wdata = wdata_q;
  assign cdout         = cdout_q;
  assign cdout_oe      = oe_q;
  assign wait_n        = wait_q;
  assign timeout_flag  = tflag_q;

endmodule

// File: tb/tb_cart_mem_bridge.sv
// Directed bench for cart_mem_bridge with a simple acknowledging memory model.
module tb_cart_mem_bridge;

  localparam int unsigned AW = 23;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cart_ena = 1'b0;
  logic          ram_ena = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic          rd_n = 1'b1;
  logic          wr_n = 1'b1;
  logic [7:0]    cdin = 8'h00;
  logic [7:0]    cdout;
  logic          cdout_oe, wait_n, timeout_flag;

  always #5 clk = ~clk;

  cart_mem_bridge_if #(.ADDR_W(AW)) mif ();

  cart_mem_bridge #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(64),
    .ADDR_W        (AW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cart_ena    (cart_ena),
    .ram_ena     (ram_ena),
    .mem_addr    (mem_addr),
    .rd_n        (rd_n),
    .wr_n        (wr_n),
    .cdin        (cdin),
    .cdout       (cdout),
    .cdout_oe    (cdout_oe),
    .wait_n      (wait_n),
    .timeout_flag(timeout_flag),
    .mem         (mif)
  );

  // Memory model: acks ack_delay clocks after mem_req rises.
  int unsigned ack_delay = 5;
  bit          ack_en = 1'b1;
  logic        late_ack = 1'b0;
  logic        resp_ack;
  int unsigned wcnt;
  logic [7:0]  rdata = 8'h00;

  assign mif.mem_ack   = resp_ack | late_ack;
  assign mif.mem_rdata = rdata;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_ack <= 1'b0;
      wcnt     <= 0;
    end else begin
      resp_ack <= 1'b0;
      if (mif.mem_req && !resp_ack) begin
        if (wcnt == ack_delay - 1) begin
          resp_ack <= ack_en;
          wcnt     <= 0;
        end else begin
          wcnt <= wcnt + 1;
        end
      end else begin
        wcnt <= 0;
      end
    end
  end

  logic req_prev = 1'b0;
  int   rd_reqs = 0;
  int   wr_reqs = 0;

  always @(posedge clk) begin
    req_prev <= mif.mem_req;
    if (mif.mem_req && !req_prev) begin
      if (mif.mem_we) wr_reqs <= wr_reqs + 1;
      else            rd_reqs <= rd_reqs + 1;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mif.mem_req) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq({tag, "_req_seen"}, 32'(ok), 32'd1);
  endtask

  // Called at the first negedge with mem_req high; returns at the negedge after it falls.
  task automatic count_req(output int n);
    n = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!mif.mem_req) break;
      n++;
    end
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] exp, input string tag);
    bit ok = 1'b0;
    mem_addr = addr;
    cart_ena = 1'b1;
    rd_n     = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (cdout_oe) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq({tag, "_oe"}, 32'(ok), 32'd1);
    check_eq({tag, "_data"}, 32'(cdout), 32'(exp));
    rd_n = 1'b1;
    cycles(5);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] data, input string tag);
    int n;
    mem_addr = addr;
    cdin     = data;
    ram_ena  = 1'b1;
    cart_ena = 1'b1;
    wr_n     = 1'b0;
    wait_req(tag);
    count_req(n);
    wr_n = 1'b1;
    cycles(5);
  endtask

  int  n, r0, w0;
  bit  seen_req, seen_wait;

  initial begin
    cycles(3);
    check_eq("rst_cdout", 32'(cdout), 32'hFF);
    check_eq("rst_oe", 32'(cdout_oe), 32'd0);
    check_eq("rst_wait", 32'(wait_n), 32'd1);
    check_eq("rst_req", 32'(mif.mem_req), 32'd0);
    check_eq("rst_we", 32'(mif.mem_we), 32'd0);
    check_eq("rst_a", 32'(mif.mem_a), 32'd0);
    check_eq("rst_wdata", 32'(mif.mem_wdata), 32'd0);
    check_eq("rst_tflag", 32'(timeout_flag), 32'd0);
    reset_n = 1'b1;
    cycles(3);

    // Basic read, ack 5 clocks after request
    rdata    = 8'hA5;
    mem_addr = 23'h420123;
    cart_ena = 1'b1;
    rd_n     = 1'b0;
    wait_req("rd");
    check_eq("rd_a", 32'(mif.mem_a), 32'h420123);
    check_eq("rd_we", 32'(mif.mem_we), 32'd0);
    check_eq("rd_wait_low", 32'(wait_n), 32'd0);
    check_eq("rd_oe_during_req", 32'(cdout_oe), 32'd0);
    count_req(n);
    check_eq("rd_req_cycles", 32'(n), 32'd6);
    check_eq("rd_cdout", 32'(cdout), 32'hA5);
    check_eq("rd_oe", 32'(cdout_oe), 32'd1);
    check_eq("rd_wait_rel", 32'(wait_n), 32'd1);
    cycles(3);
    check_eq("rd_oe_hold", 32'(cdout_oe), 32'd1);
    rd_n = 1'b1;
    cycles(4);
    check_eq("rd_oe_off", 32'(cdout_oe), 32'd0);
    check_eq("rd_cdout_kept", 32'(cdout), 32'hA5);

    // RAM-mode write
    ram_ena  = 1'b1;
    cdin     = 8'h3C;
    mem_addr = 23'h000055;
    wr_n     = 1'b0;
    wait_req("wr");
    check_eq("wr_we", 32'(mif.mem_we), 32'd1);
    check_eq("wr_wdata", 32'(mif.mem_wdata), 32'h3C);
    check_eq("wr_a", 32'(mif.mem_a), 32'h55);
    check_eq("wr_wait_low", 32'(wait_n), 32'd0);
    count_req(n);
    check_eq("wr_req_cycles", 32'(n), 32'd6);
    check_eq("wr_wait_rel", 32'(wait_n), 32'd1);
    check_eq("wr_oe", 32'(cdout_oe), 32'd0);
    wr_n = 1'b1;
    cycles(5);

    // ROM-mode write: never reaches memory
    w0        = wr_reqs;
    ram_ena   = 1'b0;
    cdin      = 8'h77;
    wr_n      = 1'b0;
    seen_req  = 1'b0;
    seen_wait = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mif.mem_req) seen_req = 1'b1;
      if (!wait_n) seen_wait = 1'b1;
    end
    check_eq("rom_no_req", 32'(seen_req), 32'd0);
    check_eq("rom_no_wait", 32'(seen_wait), 32'd0);
    check_eq("rom_oe", 32'(cdout_oe), 32'd0);
    wr_n = 1'b1;
    cycles(5);
    check_eq("rom_wr_count", 32'(wr_reqs - w0), 32'd0);
    rdata = 8'h96;
    do_read(23'h000400, 8'h96, "after_rom");

    // Both strobes asserted together: no start
    rd_n     = 1'b0;
    wr_n     = 1'b0;
    seen_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mif.mem_req) seen_req = 1'b1;
    end
    check_eq("both_no_req", 32'(seen_req), 32'd0);
    rd_n = 1'b1;
    wr_n = 1'b1;
    cycles(5);

    // Timeout
    ack_en   = 1'b0;
    mem_addr = 23'h000100;
    rd_n     = 1'b0;
    wait_req("to");
    count_req(n);
    check_eq("to_req_cycles", 32'(n), 32'd64);
    check_eq("to_cdout", 32'(cdout), 32'hFF);
    check_eq("to_oe", 32'(cdout_oe), 32'd1);
    check_eq("to_flag", 32'(timeout_flag), 32'd1);
    check_eq("to_wait", 32'(wait_n), 32'd1);
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    cycles(2);
    check_eq("late_ack_req", 32'(mif.mem_req), 32'd0);
    check_eq("late_ack_cdout", 32'(cdout), 32'hFF);
    rd_n = 1'b1;
    cycles(5);
    ack_en = 1'b1;
    rdata  = 8'h5A;
    do_read(23'h000200, 8'h5A, "after_to");
    check_eq("to_flag_sticky", 32'(timeout_flag), 32'd1);

    // Reset while the request is outstanding
    rdata    = 8'hC3;
    mem_addr = 23'h000300;
    rd_n     = 1'b0;
    wait_req("rst_mid");
    cycles(2);
    reset_n = 1'b0;
    #1;
    check_eq("rst_mid_req", 32'(mif.mem_req), 32'd0);
    check_eq("rst_mid_wait", 32'(wait_n), 32'd1);
    check_eq("rst_mid_oe", 32'(cdout_oe), 32'd0);
    check_eq("rst_mid_flag", 32'(timeout_flag), 32'd0);
    rd_n = 1'b1;
    cycles(2);
    reset_n = 1'b1;
    cycles(2);
    do_read(23'h000300, 8'hC3, "post_rst");

`ifdef CART_READ_CACHE_EN
    r0    = rd_reqs;
    w0    = wr_reqs;
    rdata = 8'h11;
    do_read(23'h420010, 8'h11, "c_rd1");
    rdata = 8'h22;
    do_read(23'h420010, 8'h11, "c_rd2_hit");
    check_eq("c_one_req", 32'(rd_reqs - r0), 32'd1);
    do_write(23'h420010, 8'h99, "c_wr");
    rdata = 8'h33;
    do_read(23'h420010, 8'h33, "c_rd3");
    check_eq("c_rd_reqs", 32'(rd_reqs - r0), 32'd2);
    check_eq("c_wr_reqs", 32'(wr_reqs - w0), 32'd1);
`else
    r0    = rd_reqs;
    rdata = 8'h11;
    do_read(23'h420010, 8'h11, "nc_rd1");
    rdata = 8'h22;
    do_read(23'h420010, 8'h22, "nc_rd2");
    check_eq("nc_two_reqs", 32'(rd_reqs - r0), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cart_mem_bridge.md
Name: cart_mem_bridge

Overview:
- Downstream of the MegaRAM/SCC mapper. Turns each mapped cartridge bus cycle into one request on the external memory port.
  - Inputs from the mapper: cart_ena, ram_ena, mem_addr.
  - Inputs from the MSX bus: rd_n, wr_n.
- Read data returns on cdout with a drive-enable.
- Writes reach memory only in RAM mode; in ROM mode they are bank-register writes and are never stored.
- Drives the MSX wait_n line so the Z80 is stalled until memory completes.

Parameters:
- SYNC_STAGES, 2: synchroniser depth for rd_n, wr_n, cart_ena (minimum 2).
- TIMEOUT_CYCLES, 64: clk cycles from mem_req rise without mem_ack before the access is abandoned.
- ADDR_W, 23: memory address width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cart_ena  in  1  mapper: access hits cartridge window
- ram_ena  in  1  mapper: RAM mode (1) / ROM mode (0)
- mem_addr  in  ADDR_W  mapper: translated address
- rd_n  in  1  MSX read strobe
- wr_n  in  1  MSX write strobe
- cdin  in  8  MSX write data
- cdout  out  8  read data to MSX bus
- cdout_oe  out  1  drive cdout onto bus
- wait_n  out  1  MSX WAIT, low = stall CPU
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_a  out  ADDR_W  latched address
- mem_wdata  out  8  latched write data
- mem_ack  in  1  one-cycle completion pulse
- mem_rdata  in  8  valid in mem_ack cycle
- timeout_flag  out  1  sticky, set on any timeout

Behaviour:
- Reset values: cdout=8'hFF, cdout_oe=0, wait_n=1, mem_req=0, mem_we=0, mem_a=0, mem_wdata=0, timeout_flag=0. State=IDLE.
- Reset mid-access drops mem_req at once. The memory controller tolerates an abandoned request.
- Synchronisation: rd_n, wr_n, cart_ena pass through SYNC_STAGES flops. rd_s/wr_s/ce_s denote the synchronised active-high strobes.
- Start condition: ce_s=1 and exactly one of rd_s/wr_s newly asserted (rising edge of rd_s|wr_s).
  - Both strobes low together: no start, stay IDLE.
- FSM states: IDLE, REQ, HOLD.
- IDLE → REQ, on start when: read; or write with ram_ena=1.
  - Latch mem_a=mem_addr, mem_wdata=cdin, mem_we=wr_s.
  - mem_req=1 and wait_n=0 on the next clk edge.
- IDLE → HOLD, on a write start with ram_ena=0 (ROM mode).
  - No mem_req, no wait.
- REQ: mem_req held high until mem_ack (level req / pulse ack).
  - On mem_ack: mem_req=0 next edge, wait_n=1. Reads also load cdout=mem_rdata and set cdout_oe=1. Go to HOLD.
  - Cycle counter reaches TIMEOUT_CYCLES without ack: mem_req=0, wait_n=1, cdout=8'hFF, cdout_oe=1 on reads, timeout_flag=1. Go to HOLD.
  - A late mem_ack after timeout is ignored.
- HOLD: remain until rd_s and wr_s both deasserted.
  - Then cdout_oe=0 and go to IDLE. cdout keeps its last value.
- Latency, ack-to-data: cdout valid one clk after mem_ack. Minimum read path = SYNC_STAGES + 1 + memory latency + 1 clk.
- Strobe lost in REQ (CPU aborted): complete the handshake, discard data, go straight to IDLE.
- cart_ena dropping mid-access has no effect; address and data are already latched.
- mem_a, mem_wdata, mem_we are stable whenever mem_req=1.
- timeout_flag clears only on reset.

Optional Feature:
- CART_READ_CACHE_EN
- Defined: single-entry read cache.
  - A read start whose mem_addr equals the last completed read address, with no memory write since and the valid bit set, goes IDLE → HOLD.
  - cdout = cached byte, cdout_oe=1 one clk after start. No mem_req, wait_n stays 1.
  - Any memory write or any timeout invalidates the entry.
  - Reset clears the valid bit.
- Undefined: every read issues a memory request.

Decomposition:
- Shared package cart_pkg:
  - state enum (IDLE, REQ, HOLD)
  - constant IDLE_DATA=8'hFF
  - default ADDR_W
- One natural sub-module: cart_sync, an N-stage synchroniser with rising-edge detect, instantiated three times.

Test Plan:
- Read, RAM or ROM mode: cart_ena=1, mem_addr=23'h420123, rd_n falls; memory acks after 5 clk with 8'hA5 → mem_req high until ack, mem_a=23'h420123, mem_we=0, wait_n low during REQ, cdout=8'hA5 with cdout_oe=1 until rd_n rises.
- Write in RAM mode: ram_ena=1, cdin=8'h3C, wr_n falls → mem_req with mem_we=1, mem_wdata=8'h3C, wait_n released on ack, cdout_oe stays 0.
- Write in ROM mode: ram_ena=0, wr_n falls → no mem_req at any time, wait_n stays 1, FSM returns to IDLE after wr_n rises.
- Timeout: mem_ack never asserted on a read → mem_req drops after TIMEOUT_CYCLES=64, cdout=8'hFF, timeout_flag=1. Later ack ignored, next read proceeds normally.
- Reset mid-REQ: assert reset_n=0 while mem_req=1 → mem_req, wait_n=1, cdout_oe=0 immediately; the first access after release completes correctly.
- Cache, with CART_READ_CACHE_EN: two reads of 23'h420010 → one mem_req only. Read, write same address, read → two read requests plus the write.
